// File: rtl/fifo_serial_drain_if.sv
// ----------------------------------------------------------------------------
// fifo_serial_drain_if
// Read-side handshake between the SSP transmit FIFO and its serial drain.
//   fifo_empty    FIFO -> drain   FIFO empty flag
//   fifo_data     FIFO -> drain   registered read data (updates on pop edge)
//   fifo_read_en  drain -> FIFO   one-cycle pop request
// Modports: master = drain (issues pops), slave = FIFO.
// ----------------------------------------------------------------------------
interface fifo_serial_drain_if #(
    parameter int DATA_W = 28
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );
endinterface

// File: rtl/fifo_serial_drain.sv
// ----------------------------------------------------------------------------
// fifo_serial_drain
// Read end of the 28-bit sync FIFO: pops one word at a time while tx_en is
// high and the FIFO is non-empty, then shifts it out MSB-first on a 3-wire
// serial link (sclk/sdata/frame), followed by an idle gap.
// Optional feature macro: PARITY_EN -- appends an odd-parity bit to each frame.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous reset, active-low
//   tx_en        in   enables starting new frames
//   fifo_rd      if   FIFO read port (master modport: empty/data in, read_en out)
//   sclk_out     out  serial clock, idles low, rises mid-bit
//   sdata_out    out  serial data, changes when sclk falls
//   frame_out    out  high for the whole first bit of each frame
//   busy         out  high in any state except IDLE
//   sent_count   out  frames fully sent, wraps 0xFFFF -> 0
// ----------------------------------------------------------------------------
module fifo_serial_drain #(
    parameter int DATA_W   = 28,
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tx_en,
    fifo_serial_drain_if.master fifo_rd,
    output logic                sclk_out,
    output logic                sdata_out,
    output logic                frame_out,
    output logic                busy,
    output logic [15:0]         sent_count
);

`ifdef PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = $clog2(GAP_CYC);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [15:0]        r_sent_count;
    logic               r_read_en;
    logic               r_sclk;
    logic               r_sdata;
    logic               r_frame;
    logic               r_busy;

    state_t             w_state_nx;
    logic [FRAME_W-1:0] w_shreg_nx;
    logic [DIV_W-1:0]   w_div_nx;
    logic [BIT_W-1:0]   w_bit_nx;
    logic [GAP_W-1:0]   w_gap_nx;
    logic [15:0]        w_count_nx;
    logic [FRAME_W-1:0] w_load_word;

`ifdef PARITY_EN
    // Odd parity: appended bit makes the total number of ones odd.
    assign w_load_word = {fifo_rd.fifo_data, ~^fifo_rd.fifo_data};
`else
    assign w_load_word = fifo_rd.fifo_data;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_div_nx   = r_div_cnt;
        w_bit_nx   = r_bit_cnt;
        w_gap_nx   = r_gap_cnt;
        w_count_nx = r_sent_count;
        case (r_state)
            ST_IDLE: begin
                if (tx_en && !fifo_rd.fifo_empty) begin
                    w_state_nx = ST_POP;
                end
            end
            ST_POP: begin
                w_state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                // fifo_data was refreshed by the FIFO on the POP edge.
                w_shreg_nx = w_load_word;
                w_div_nx   = '0;
                w_bit_nx   = '0;
                w_state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nx   = '0;
                    w_shreg_nx = {r_shreg[FRAME_W-2:0], 1'b0};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_nx   = '0;
                        w_gap_nx   = '0;
                        w_count_nx = r_sent_count + 16'd1;
                        w_state_nx = ST_GAP;
                    end else begin
                        w_bit_nx = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_div_nx = r_div_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sent_count <= '0;
            r_read_en    <= 1'b0;
            r_sclk       <= 1'b0;
            r_sdata      <= 1'b0;
            r_frame      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shreg      <= w_shreg_nx;
            r_div_cnt    <= w_div_nx;
            r_bit_cnt    <= w_bit_nx;
            r_gap_cnt    <= w_gap_nx;
            r_sent_count <= w_count_nx;
            r_read_en    <= (w_state_nx == ST_POP);
            r_sclk       <= (w_state_nx == ST_SHIFT) && (w_div_nx >= DIV_HALF);
            r_sdata      <= (w_state_nx == ST_SHIFT) && w_shreg_nx[FRAME_W-1];
            r_frame      <= (w_state_nx == ST_SHIFT) && (w_bit_nx == '0);
            r_busy       <= (w_state_nx != ST_IDLE);
        end
    end

    assign fifo_rd.fifo_read_en = r_read_en;
    assign sclk_out             = r_sclk;
    assign sdata_out            = r_sdata;
    assign frame_out            = r_frame;
    assign busy                 = r_busy;
    assign sent_count           = r_sent_count;

endmodule
